// File: rtl/hdmi_pll_supervisor_pkg.sv
// Shared HDMI clocking definitions: supervisor FSM states and 27 MHz-derived
// default timing constants.
package hdmi_pll_supervisor_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    FILTER    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int CLK_HZ                  = 27_000_000;
  localparam int DEF_LOCK_FILTER_CYCLES  = CLK_HZ / 100_000;  // 10 us
  localparam int DEF_PLL_RESET_CYCLES    = CLK_HZ / 1_000_000; // 1 us
  localparam int DEF_LOCK_TIMEOUT_CYCLES = CLK_HZ / 1_000;    // 1 ms

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hdmi_pll_supervisor_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hdmi_pll_supervisor.sv
// Sequences the HDMI PLL reset, qualifies its lock signal and releases the
// TMDS encoder/serializer reset only once lock has been stable long enough.
module hdmi_pll_supervisor
  import hdmi_pll_supervisor_pkg::*;
#(
  parameter int LOCK_FILTER_CYCLES  = DEF_LOCK_FILTER_CYCLES,
  parameter int PLL_RESET_CYCLES    = DEF_PLL_RESET_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked_in,
  output logic       pll_reset,
  output logic       ready,
  output logic       reset_out,
  output logic [7:0] lock_loss_count,
  output logic [7:0] timeout_count,
  output state_t     state_dbg
);

  localparam int CNT_W = $clog2(max3(LOCK_FILTER_CYCLES, PLL_RESET_CYCLES,
                                     LOCK_TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] LF_LAST = CNT_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] PR_LAST = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  if (LOCK_FILTER_CYCLES < 1 || PLL_RESET_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1)
  begin : g_bad_params
    $error("hdmi_pll_supervisor: all cycle parameters must be >= 1");
  end

  logic             locked_sync;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             timeout_evt;
  logic             loss_evt;

  sync_2ff #(.RESET_VAL(1'b0)) u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d     (locked_in),
    .q     (locked_sync)
  );

  // A lost lock always wins over a completed filter window.
  always_comb begin
    state_nxt   = state;
    timeout_evt = 1'b0;
    loss_evt    = 1'b0;
    case (state)
      RESET_PLL: if (cnt == PR_LAST) state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        if (locked_sync) begin
          state_nxt = FILTER;
        end else if (cnt == TO_LAST) begin
          state_nxt   = RESET_PLL;
          timeout_evt = 1'b1;
        end
      end
      FILTER: begin
        if (!locked_sync)        state_nxt = WAIT_LOCK;
        else if (cnt == LF_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (!locked_sync) begin
          state_nxt = RESET_PLL;
          loss_evt  = 1'b1;
        end
      end
      default: state_nxt = RESET_PLL;
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= RESET_PLL;
      cnt             <= '0;
      pll_reset       <= 1'b1;
      ready           <= 1'b0;
      reset_out       <= 1'b1;
      lock_loss_count <= 8'd0;
      timeout_count   <= 8'd0;
    end else begin
      state     <= state_nxt;
      pll_reset <= (state_nxt == RESET_PLL);
      ready     <= (state_nxt == RUN);
      reset_out <= (state_nxt != RUN);
      if (state_nxt != state)  cnt <= '0;
      else if (state != RUN)   cnt <= cnt + CNT_W'(1);
      if (timeout_evt && timeout_count != 8'hFF)
        timeout_count <= timeout_count + 8'd1;
      if (loss_evt && lock_loss_count != 8'hFF)
        lock_loss_count <= lock_loss_count + 8'd1;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_hdmi_pll_supervisor.sv
// Directed bench for hdmi_pll_supervisor with short timing parameters.
module tb_hdmi_pll_supervisor;
  import hdmi_pll_supervisor_pkg::*;

  logic       clock;
  logic       reset;
  logic       locked_in;
  logic       pll_reset;
  logic       ready;
  logic       reset_out;
  logic [7:0] lock_loss_count;
  logic [7:0] timeout_count;
  state_t     state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  hdmi_pll_supervisor #(
    .LOCK_FILTER_CYCLES  (8),
    .PLL_RESET_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (64)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .locked_in       (locked_in),
    .pll_reset       (pll_reset),
    .ready           (ready),
    .reset_out       (reset_out),
    .lock_loss_count (lock_loss_count),
    .timeout_count   (timeout_count),
    .state_dbg       (state_dbg)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    locked_in = 1'b0;
    repeat (2) tick();

    chk("rst_state", 32'(state_dbg), 32'(RESET_PLL));
    chk("rst_pll_reset", 32'(pll_reset), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_reset_out", 32'(reset_out), 32'd1);
    chk("rst_loss", 32'(lock_loss_count), 32'd0);
    chk("rst_timeout", 32'(timeout_count), 32'd0);

    // Release with no lock: 4-clock pll_reset pulse
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("rel_pll_reset", 32'(pll_reset), (k < 4) ? 32'd1 : 32'd0);
      chk("rel_ready", 32'(ready), 32'd0);
    end

    // Timeouts every 68 clocks
    for (int t = 1; t <= 3; t++) begin
      repeat (63) tick();
      chk("to_pre_pll", 32'(pll_reset), 32'd0);
      chk("to_pre_cnt", 32'(timeout_count), 32'(t - 1));
      tick();
      chk("to_pll_rise", 32'(pll_reset), 32'd1);
      chk("to_cnt", 32'(timeout_count), 32'(t));
      repeat (3) tick();
      chk("to_pll_hold", 32'(pll_reset), 32'd1);
      tick();
      chk("to_pll_fall", 32'(pll_reset), 32'd0);
    end
    repeat (252) repeat (68) tick();
    chk("to_sat", 32'(timeout_count), 32'd255);
    repeat (68) tick();
    chk("to_nowrap", 32'(timeout_count), 32'd255);
    chk("to_state", 32'(state_dbg), 32'(WAIT_LOCK));

    // Lock 10 clocks after release: ready on the 11th edge
    reset = 1'b1;
    #1;
    chk("rst2_timeout", 32'(timeout_count), 32'd0);
    tick();
    reset = 1'b0;
    repeat (10) tick();
    locked_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("lat_ready_low", 32'(ready), 32'd0);
    end
    tick();
    chk("lat_ready", 32'(ready), 32'd1);
    chk("lat_reset_out", 32'(reset_out), 32'd0);
    chk("lat_pll_reset", 32'(pll_reset), 32'd0);
    chk("lat_state", 32'(state_dbg), 32'(RUN));

    // One-clock glitch 5 clocks into FILTER restarts filtering
    reset = 1'b1;
    locked_in = 1'b0;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    locked_in = 1'b1;
    repeat (3) tick();
    chk("gl_in_filter", 32'(state_dbg), 32'(FILTER));
    repeat (5) tick();
    chk("gl_ready_pre", 32'(ready), 32'd0);
    locked_in = 1'b0;
    tick();
    locked_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("gl_ready_low", 32'(ready), 32'd0);
      if (k == 2) chk("gl_restart", 32'(state_dbg), 32'(WAIT_LOCK));
    end
    tick();
    chk("gl_ready", 32'(ready), 32'd1);
    chk("gl_loss", 32'(lock_loss_count), 32'd0);

    // 300 lock losses in RUN; count saturates at 255
    for (int i = 1; i <= 300; i++) begin
      locked_in = 1'b0;
      tick();
      tick();
      chk("loss_edge2_pll", 32'(pll_reset), 32'd0);
      chk("loss_edge2_ready", 32'(ready), 32'd1);
      tick();
      chk("loss_edge3_pll", 32'(pll_reset), 32'd1);
      chk("loss_edge3_ready", 32'(ready), 32'd0);
      chk("loss_count", 32'(lock_loss_count), (i > 255) ? 32'd255 : 32'(i));
      locked_in = 1'b1;
      wait_ready(40);
    end

    // Asynchronous reset between edges while in RUN
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_ready", 32'(ready), 32'd0);
    chk("arst_pll_reset", 32'(pll_reset), 32'd1);
    chk("arst_reset_out", 32'(reset_out), 32'd1);
    chk("arst_loss", 32'(lock_loss_count), 32'd0);
    chk("arst_timeout", 32'(timeout_count), 32'd0);
    chk("arst_state", 32'(state_dbg), 32'(RESET_PLL));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
